fp_mul_except_pipe: RTL and testbench



---
 rtl/fp_mul_except_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_fp_mul_except_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_except_pipe.sv
// fp_mul_except_pipe
// Two-stage pipelined exception stage for a floating-point multiplier.
// It classifies the operands, resolves the special cases (NaN, inf, zero and
// invalid), and substitutes results on overflow/underflow according to the
// rounding mode captured with each beat. It also keeps sticky exception flags.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   a, b                operands (W = 1+EXP_W+MAN_W)
//   z_calc              normalised/rounded datapath result
//   overflow/underflow/inexact  datapath status for this beat
//   rnd                 rounding mode for this beat (6,7 behave as 0)
//   out_valid/out_ready output handshake
//   z, flags            result and {invalid,inexact,huge,tiny,nan,inf,zero}
//   sticky, sticky_clr  accumulated flags and their clear
module fp_mul_except_pipe #(
    parameter int EXP_W        = 8,
    parameter int MAN_W        = 23,
    parameter bit FLUSH_DENORM = 1'b1,
    localparam int W           = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] z_calc,
    input  logic         overflow,
    input  logic         underflow,
    input  logic         inexact,
    input  logic [2:0]   rnd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic [6:0]   flags,
    output logic [6:0]   sticky,
    input  logic         sticky_clr
);

    localparam logic [1:0] C_ZERO = 2'd0;
    localparam logic [1:0] C_NORM = 2'd1;
    localparam logic [1:0] C_INF  = 2'd2;
    localparam logic [1:0] C_NAN  = 2'd3;

    // Flag bit positions
    localparam int F_ZERO = 0;
    localparam int F_INF  = 1;
    localparam int F_NAN  = 2;
    localparam int F_TINY = 3;
    localparam int F_HUGE = 4;
    localparam int F_INEX = 5;
    localparam int F_INV  = 6;

    function automatic logic [1:0] classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = x[W-2:MAN_W];
        m = x[MAN_W-1:0];
        if (e == '0)
            classify = (FLUSH_DENORM || m == '0) ? C_ZERO : C_NORM;
        else if (&e)
            classify = (m == '0) ? C_INF : C_NAN;
        else
            classify = C_NORM;
    endfunction

    // Stage 1 state
    logic         r_s1_valid;
    logic         r_s1_sign;
    logic [1:0]   r_s1_ca;
    logic [1:0]   r_s1_cb;
    logic [W-1:0] r_s1_zc;
    logic         r_s1_ovf;
    logic         r_s1_udf;
    logic         r_s1_inx;
    logic [2:0]   r_s1_rnd;

    // Stage 2 state
    logic         r_s2_valid;
    logic [W-1:0] r_z;
    logic [6:0]   r_flags;
    logic [6:0]   r_sticky;

    logic         w_adv1;
    logic         w_adv2;
    logic         w_s;
    logic [2:0]   w_rm;
    logic         w_ovf_inf;
    logic         w_udf_min;
    logic         w_any_nan;
    logic         w_any_inf;
    logic         w_any_zero;
    logic [W-1:0] w_z;
    logic [6:0]   w_flags;

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_ca    <= C_ZERO;
            r_s1_cb    <= C_ZERO;
            r_s1_zc    <= '0;
            r_s1_ovf   <= 1'b0;
            r_s1_udf   <= 1'b0;
            r_s1_inx   <= 1'b0;
            r_s1_rnd   <= 3'd0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= a[W-1] ^ b[W-1];
                r_s1_ca   <= classify(a);
                r_s1_cb   <= classify(b);
                r_s1_zc   <= z_calc;
                r_s1_ovf  <= overflow;
                r_s1_udf  <= underflow;
                r_s1_inx  <= inexact;
                r_s1_rnd  <= rnd;
            end
        end
    end

    assign w_s  = r_s1_sign;
    assign w_rm = (r_s1_rnd > 3'd5) ? 3'd0 : r_s1_rnd;

    // Overflow saturates to infinity when the mode rounds away from zero for
    // this sign; underflow goes to the minimum normal under the same rule,
    // except that nearest-even (0) flushes underflow but saturates overflow.
    assign w_ovf_inf = (w_rm == 3'd0) || (w_rm == 3'd4) || (w_rm == 3'd5) ||
                       (w_rm == 3'd2 && !w_s) || (w_rm == 3'd3 && w_s);
    assign w_udf_min = (w_rm == 3'd4) || (w_rm == 3'd5) ||
                       (w_rm == 3'd2 && !w_s) || (w_rm == 3'd3 && w_s);

    assign w_any_nan  = (r_s1_ca == C_NAN)  || (r_s1_cb == C_NAN);
    assign w_any_inf  = (r_s1_ca == C_INF)  || (r_s1_cb == C_INF);
    assign w_any_zero = (r_s1_ca == C_ZERO) || (r_s1_cb == C_ZERO);

    always_comb begin
        w_z     = r_s1_zc;
        w_flags = '0;
        if (w_any_nan) begin
            w_z            = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flags[F_NAN] = 1'b1;
        end else if (w_any_inf && w_any_zero) begin
            w_z            = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flags[F_NAN] = 1'b1;
            w_flags[F_INV] = 1'b1;
        end else if (w_any_inf) begin
            w_z            = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags[F_INF] = 1'b1;
        end else if (w_any_zero) begin
            w_z             = {w_s, {(W-1){1'b0}}};
            w_flags[F_ZERO] = 1'b1;
        end else if (r_s1_ovf) begin
            w_flags[F_INEX] = 1'b1;
            if (w_ovf_inf) begin
                w_z            = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_flags[F_INF] = 1'b1;
            end else begin
                w_z             = {w_s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                w_flags[F_HUGE] = 1'b1;
            end
        end else if (r_s1_udf) begin
            w_flags[F_INEX] = 1'b1;
            if (w_udf_min) begin
                w_z             = {w_s, {(EXP_W-1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
                w_flags[F_TINY] = 1'b1;
            end else begin
                w_z             = {w_s, {(W-1){1'b0}}};
                w_flags[F_ZERO] = 1'b1;
            end
        end else begin
            w_flags[F_INEX] = r_s1_inx;
            w_flags[F_ZERO] = (r_s1_zc[W-2:0] == '0);
            w_flags[F_INF]  = &r_s1_zc[W-2:MAN_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_z        <= '0;
            r_flags    <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_z     <= w_z;
                r_flags <= w_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_sticky <= '0;
        else
            r_sticky <= (sticky_clr ? 7'd0 : r_sticky) |
                        ((r_s2_valid && out_ready) ? r_flags : 7'd0);
    end

    assign out_valid = r_s2_valid;
    assign z         = r_z;
    assign flags     = r_flags;
    assign sticky    = r_sticky;

endmodule

// File: tb/tb_fp_mul_except_pipe.sv
module tb_fp_mul_except_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0, z_calc = '0;
    logic        overflow = 1'b0, underflow = 1'b0, inexact = 1'b0;
    logic [2:0]  rnd = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] z;
    logic [6:0]  flags;
    logic [6:0]  sticky;
    logic        sticky_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    fp_mul_except_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .z_calc(z_calc), .overflow(overflow),
        .underflow(underflow), .inexact(inexact), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .flags(flags),
        .sticky(sticky), .sticky_clr(sticky_clr)
    );

    always #5 clk = ~clk;

    // Reference: IEEE-style single precision with denormals flushed to zero.
    // Overflow goes to infinity when the mode rounds away from zero for the
    // result sign, otherwise to the largest finite; underflow goes to the
    // smallest normal when the mode rounds away from zero, otherwise to zero.
    function automatic logic [38:0] ref_mul(input logic [31:0] ia, ib, izc,
                                            input logic iov, iun, iix,
                                            input logic [2:0] irnd);
        logic s;
        int   m;
        logic an, bn, ai, bi, az, bz, away_ovf, away_udf;
        s  = ia[31] ^ ib[31];
        m  = (irnd > 5) ? 0 : int'(irnd);
        an = (ia[30:23] == 8'hFF) && (ia[22:0] != 0);
        bn = (ib[30:23] == 8'hFF) && (ib[22:0] != 0);
        ai = (ia[30:23] == 8'hFF) && (ia[22:0] == 0);
        bi = (ib[30:23] == 8'hFF) && (ib[22:0] == 0);
        az = (ia[30:23] == 8'h00);
        bz = (ib[30:23] == 8'h00);
        case (m)
            0:       begin away_ovf = 1;  away_udf = 0;  end
            1:       begin away_ovf = 0;  away_udf = 0;  end
            2:       begin away_ovf = !s; away_udf = !s; end
            3:       begin away_ovf = s;  away_udf = s;  end
            default: begin away_ovf = 1;  away_udf = 1;  end
        endcase
        if (an || bn)                 return {32'h7FC00000, 7'h04};
        if ((az && bi) || (ai && bz)) return {32'h7FC00000, 7'h44};
        if (ai || bi)                 return {s, 31'h7F800000, 7'h02};
        if (az || bz)                 return {s, 31'h0, 7'h01};
        if (iov)
            return away_ovf ? {s, 31'h7F800000, 7'h22} : {s, 31'h7F7FFFFF, 7'h30};
        if (iun)
            return away_udf ? {s, 31'h00800000, 7'h28} : {s, 31'h0, 7'h21};
        return {izc, 1'b0, iix, 3'b000, izc[30:23] == 8'hFF, izc[30:0] == 0};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[30:0] = '0;
            1: r[30:23] = 8'h00;
            2: r[30:0] = {8'hFF, 23'h0};
            3: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
            default: if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'h80;
        endcase
        return r;
    endfunction

    // Pushes one beat through with out_ready=1; returns the result, the
    // cycles from accept to out_valid, and whether a bound expired.
    task automatic run_one(input logic [31:0] ia, ib, izc, input logic iov, iun, iix,
                           input logic [2:0] irnd, input bit clr,
                           output logic [31:0] oz, output logic [6:0] of,
                           output int lat, output bit tmo);
        bit acc;
        a = ia; b = ib; z_calc = izc; overflow = iov; underflow = iun;
        inexact = iix; rnd = irnd; in_valid = 1'b1;
        acc = 0; tmo = 1; lat = 0; oz = 'x; of = 'x;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) return;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid && out_ready) begin
                oz = z; of = flags; tmo = 0;
                if (clr) sticky_clr = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        sticky_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, z, flags, sticky} !== 47'd0) begin
            bad++;
            $display("FAIL reset_state: got ov=%b z=%h fl=%h st=%h want all 0",
                     out_valid, z, flags, sticky);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] oz; logic [6:0] of; int lat; bit tmo;
        run_one(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 3'd0, 0, oz, of, lat, tmo);
        total++;
        if (tmo || oz !== 32'h40C00000 || of !== 7'h00) begin
            bad++;
            $display("FAIL basic_mul: got tmo=%b z=%h fl=%h want z=40c00000 fl=00", tmo, oz, of);
        end
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 2", lat);
        end
    endtask

    task automatic test_special();
        logic [31:0] oz; logic [6:0] of; int lat; bit tmo;
        run_one(32'h00000000, 32'hFF800000, 32'h12345678, 0, 0, 0, 3'd0, 0, oz, of, lat, tmo);
        total++;
        if (tmo || oz !== 32'h7FC00000 || of !== 7'h44) begin
            bad++;
            $display("FAIL zero_x_inf: got z=%h fl=%h want 7fc00000/44", oz, of);
        end
        run_one(32'h7F800001, 32'h3F800000, 32'h12345678, 0, 0, 0, 3'd0, 0, oz, of, lat, tmo);
        total++;
        if (tmo || oz !== 32'h7FC00000 || of !== 7'h04) begin
            bad++;
            $display("FAIL nan_in: got z=%h fl=%h want 7fc00000/04", oz, of);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [31:0] oz; logic [6:0] of; int lat; bit tmo;
        logic [2:0]  rm[6]   = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd0, 3'd7};
        logic        ov[6]   = '{1, 1, 1, 0, 0, 0};
        logic [31:0] ez[6]   = '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000,
                                 32'h00800000, 32'h00000000, 32'h00000000};
        logic [6:0]  ef[6]   = '{7'h30, 7'h30, 7'h22, 7'h28, 7'h21, 7'h21};
        for (int i = 0; i < 6; i++) begin
            if (ov[i])
                run_one(32'hFF000000, 32'h7F000000, 32'h7F000000, 1, 0, 1, rm[i], 0, oz, of, lat, tmo);
            else
                run_one(32'h3F800000, 32'h3F800000, 32'h00000001, 0, 1, 1, rm[i], 0, oz, of, lat, tmo);
            total++;
            if (tmo || oz !== ez[i] || of !== ef[i]) begin
                bad++;
                $display("FAIL ovf_udf[%0d] rnd=%0d: got z=%h fl=%h want z=%h fl=%h",
                         i, rm[i], oz, of, ez[i], ef[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        logic [31:0] held;
        int idx, acc;
        idx = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 60 && got_q.size() < 4; cyc++) begin
            if (cyc == 4) out_ready = 1'b1;
            in_valid = (idx < 4);
            a = 32'h3F800000; b = 32'h40000000; z_calc = 32'h41000000 + idx;
            overflow = 0; underflow = 0; inexact = 0; rnd = 3'd0;
            @(negedge clk);
            if (cyc == 2) begin
                total++;
                if (idx !== 2 || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_in_ready: got accepted=%0d in_ready=%b want 2/0", idx, in_ready);
                end
                held = z;
            end
            if (cyc == 3) begin
                total++;
                if (!out_valid || z !== held || z !== 32'h41000000) begin
                    bad++;
                    $display("FAIL bp_hold: got ov=%b z=%h want 1/41000000", out_valid, z);
                end
            end
            if (out_valid && out_ready) got_q.push_back(z);
            if (in_valid && in_ready) begin
                exp_q.push_back(32'h41000000 + idx);
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (got_q.size() != 4) begin
            bad++;
            $display("FAIL bp_count: got %0d results want 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_sticky();
        logic [31:0] oz; logic [6:0] of; int lat; bit tmo;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        run_one(32'hFF000000, 32'h7F000000, 32'h7F000000, 1, 0, 1, 3'd1, 0, oz, of, lat, tmo);
        run_one(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 3'd0, 0, oz, of, lat, tmo);
        @(negedge clk);
        total++;
        if (tmo || sticky !== 7'h30) begin
            bad++;
            $display("FAIL sticky_accum: got %h want 30", sticky);
        end
        run_one(32'h00000000, 32'h3F800000, 32'h00000000, 0, 0, 0, 3'd0, 1, oz, of, lat, tmo);
        @(negedge clk);
        total++;
        if (tmo || sticky !== 7'h01) begin
            bad++;
            $display("FAIL sticky_clr_hs: got %h want 01", sticky);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [38:0] q[$];
        logic [38:0] e;
        int sent;
        sent = 0;
        for (int cyc = 0; cyc < 3000 && (sent < 300 || q.size() > 0); cyc++) begin
            in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = rand_op(); b = rand_op();
            z_calc = $urandom;
            if ($urandom_range(0, 7) == 0) z_calc[30:0] = '0;
            if ($urandom_range(0, 7) == 0) z_calc[30:23] = 8'hFF;
            overflow  = ($urandom_range(0, 3) == 0);
            underflow = ($urandom_range(0, 3) == 0);
            inexact   = 1'($urandom);
            rnd       = 3'($urandom);
            @(negedge clk);
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra: unexpected result z=%h", z);
                end else begin
                    e = q.pop_front();
                    if ({z, flags} !== e) begin
                        bad++;
                        $display("FAIL rand_result: got z=%h fl=%h want z=%h fl=%h",
                                 z, flags, e[38:7], e[6:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_mul(a, b, z_calc, overflow, underflow, inexact, rnd));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (sent != 300 || q.size() != 0) begin
            bad++;
            $display("FAIL rand_drain: got sent=%0d pending=%0d want 300/0", sent, q.size());
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        out_ready = 1'b0;
        a = 32'hFF000000; b = 32'h7F000000; overflow = 1; inexact = 1; rnd = 3'd1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || sticky !== 7'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid: got ov=%b st=%h rdy=%b want 0/00/1", out_valid, sticky, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rst_drop: got out_valid after reset want none");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_overflow_underflow();
        test_backpressure();
        test_sticky();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
